// File: rtl/core_pkg.sv
// Shared definitions for the ARM-subset lab core: control bundle layout and command/mode encodings.
package core_pkg;

  localparam int unsigned CTRL_W      = 9;
  localparam int unsigned EXE_CMD_W   = 4;
  localparam int unsigned SHIFT_W     = 12;
  localparam int unsigned SIMM_W      = 24;
  localparam int unsigned REG_IDX_W   = 4;

  // Control bundle bit positions: {exe_cmd[3:0], mem_read, mem_write, wb_en, branch_en, status_s}
  localparam int unsigned EXE_CMD_MSB = 8;
  localparam int unsigned MEM_R       = 4;
  localparam int unsigned MEM_W       = 3;
  localparam int unsigned WB          = 2;
  localparam int unsigned BR          = 1;
  localparam int unsigned S           = 0;

  typedef enum logic [EXE_CMD_W-1:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    MODE_COMPUTE = 2'b00,
    MODE_MEMORY  = 2'b01,
    MODE_BRANCH  = 2'b10
  } mode_e;

endpackage

// File: rtl/pipe_field_reg.sv
// Pipeline field register: synchronous active-low reset, flush loads zero, freeze holds.
module pipe_field_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         freeze,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n)       q <= '0;
    else if (flush)   q <= '0;
    else if (!freeze) q <= d;
  end

endmodule

// File: rtl/id_stage_reg.sv
// ID/EX pipeline register with freeze/flush and a saturating flush-bubble counter.
// Define ID_STAGE_FWD_EN to register the forwarding fields (src1/src2/one_input); otherwise they are tied to 0.
module id_stage_reg
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic [CTRL_W-1:0]    ctrl_in,
  input  logic                 one_input_in,
  input  logic [DATA_W-1:0]    pc_in,
  input  logic [DATA_W-1:0]    rn_val_in,
  input  logic [DATA_W-1:0]    rm_val_in,
  input  logic                 imm_in,
  input  logic [SHIFT_W-1:0]   shift_operand_in,
  input  logic [SIMM_W-1:0]    simm24_in,
  input  logic [REG_IDX_W-1:0] dest_in,
  input  logic [REG_IDX_W-1:0] src1_in,
  input  logic [REG_IDX_W-1:0] src2_in,
  input  logic                 carry_in,
  output logic [EXE_CMD_W-1:0] exe_cmd,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 wb_en,
  output logic                 branch_en,
  output logic                 status_s,
  output logic [DATA_W-1:0]    pc,
  output logic [DATA_W-1:0]    rn_val,
  output logic [DATA_W-1:0]    rm_val,
  output logic                 imm,
  output logic [SHIFT_W-1:0]   shift_operand,
  output logic [SIMM_W-1:0]    simm24,
  output logic [REG_IDX_W-1:0] dest,
  output logic                 carry,
  output logic [REG_IDX_W-1:0] src1_out,
  output logic [REG_IDX_W-1:0] src2_out,
  output logic                 one_input_out,
  output logic                 valid,
  output logic [CNT_W-1:0]     bubble_count
);

  localparam int unsigned DATA_GRP_W = 3 * DATA_W;
  localparam int unsigned FLD_GRP_W  = 1 + SHIFT_W + SIMM_W + REG_IDX_W + 1;
  localparam int unsigned FWD_GRP_W  = 2 * REG_IDX_W + 1;

  logic [CTRL_W-1:0]     ctrl_q;
  logic [DATA_GRP_W-1:0] data_q;
  logic [FLD_GRP_W-1:0]  fld_q;

  pipe_field_reg #(.W(CTRL_W)) u_ctrl (
    .clk(clk), .rst_n(rst_n), .flush(flush), .freeze(freeze),
    .d(ctrl_in), .q(ctrl_q)
  );

  pipe_field_reg #(.W(DATA_GRP_W)) u_data (
    .clk(clk), .rst_n(rst_n), .flush(flush), .freeze(freeze),
    .d({pc_in, rn_val_in, rm_val_in}), .q(data_q)
  );

  pipe_field_reg #(.W(FLD_GRP_W)) u_fld (
    .clk(clk), .rst_n(rst_n), .flush(flush), .freeze(freeze),
    .d({imm_in, shift_operand_in, simm24_in, dest_in, carry_in}), .q(fld_q)
  );

  // A load always marks the slot valid; flush turns it into a bubble.
  pipe_field_reg #(.W(1)) u_valid (
    .clk(clk), .rst_n(rst_n), .flush(flush), .freeze(freeze),
    .d(1'b1), .q(valid)
  );

  assign exe_cmd   = ctrl_q[EXE_CMD_MSB -: EXE_CMD_W];
  assign mem_read  = ctrl_q[MEM_R];
  assign mem_write = ctrl_q[MEM_W];
  assign wb_en     = ctrl_q[WB];
  assign branch_en = ctrl_q[BR];
  assign status_s  = ctrl_q[S];

  assign {pc, rn_val, rm_val} = data_q;
  assign {imm, shift_operand, simm24, dest, carry} = fld_q;

`ifdef ID_STAGE_FWD_EN
  logic [FWD_GRP_W-1:0] fwd_q;

  pipe_field_reg #(.W(FWD_GRP_W)) u_fwd (
    .clk(clk), .rst_n(rst_n), .flush(flush), .freeze(freeze),
    .d({src1_in, src2_in, one_input_in}), .q(fwd_q)
  );

  assign {src1_out, src2_out, one_input_out} = fwd_q;
`else
  logic unused_fwd;

  assign unused_fwd    = ^{src1_in, src2_in, one_input_in};
  assign src1_out      = '0;
  assign src2_out      = '0;
  assign one_input_out = 1'b0;
`endif

  // Flush bubbles are counted even under freeze; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n)
      bubble_count <= '0;
    else if (flush && (bubble_count != {CNT_W{1'b1}}))
      bubble_count <= bubble_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_id_stage_reg.sv
// Scoreboard bench for id_stage_reg: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_id_stage_reg;

  typedef struct packed {
    logic [8:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] simm;
    logic [3:0]  dest;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        one;
    logic        carry;
  } fields_t;

  typedef struct packed {
    fields_t    f;
    logic       valid;
    logic [3:0] bc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic freeze = 1'b0;
  logic flush = 1'b0;
  fields_t din = '0;

  logic [3:0]  exe_cmd;
  logic        mem_read, mem_write, wb_en, branch_en, status_s;
  logic [31:0] pc, rn_val, rm_val;
  logic        imm;
  logic [11:0] shift_operand;
  logic [23:0] simm24;
  logic [3:0]  dest, src1_out, src2_out;
  logic        carry, one_input_out, valid;
  logic [3:0]  bubble_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  id_stage_reg #(.DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
    .ctrl_in(din.ctrl), .one_input_in(din.one), .pc_in(din.pc),
    .rn_val_in(din.rn), .rm_val_in(din.rm), .imm_in(din.imm),
    .shift_operand_in(din.sh), .simm24_in(din.simm), .dest_in(din.dest),
    .src1_in(din.s1), .src2_in(din.s2), .carry_in(din.carry),
    .exe_cmd(exe_cmd), .mem_read(mem_read), .mem_write(mem_write),
    .wb_en(wb_en), .branch_en(branch_en), .status_s(status_s),
    .pc(pc), .rn_val(rn_val), .rm_val(rm_val), .imm(imm),
    .shift_operand(shift_operand), .simm24(simm24), .dest(dest),
    .carry(carry), .src1_out(src1_out), .src2_out(src2_out),
    .one_input_out(one_input_out), .valid(valid), .bubble_count(bubble_count)
  );

  function automatic fields_t fwd_mask(input fields_t f);
    fields_t r;
    r = f;
`ifndef ID_STAGE_FWD_EN
    r.s1  = '0;
    r.s2  = '0;
    r.one = 1'b0;
`endif
    return r;
  endfunction

  function automatic fields_t rnd_fields();
    fields_t r;
    r.ctrl  = 9'($urandom);
    r.pc    = $urandom;
    r.rn    = $urandom;
    r.rm    = $urandom;
    r.imm   = 1'($urandom);
    r.sh    = 12'($urandom);
    r.simm  = 24'($urandom);
    r.dest  = 4'($urandom);
    r.s1    = 4'($urandom);
    r.s2    = 4'($urandom);
    r.one   = 1'($urandom);
    r.carry = 1'($urandom);
    return r;
  endfunction

  // Drive one cycle of inputs and queue what the outputs must show after the next edge.
  task automatic step(input logic r, input logic fz, input logic fl, input fields_t in,
                      input fields_t ef, input logic ev, input logic [3:0] ebc);
    exp_t e;
    @(negedge clk);
    rst_n  = r;
    freeze = fz;
    flush  = fl;
    din    = in;
    e.f     = fwd_mask(ef);
    e.valid = ev;
    e.bc    = ebc;
    sb.push_back(e);
  endtask

  // Monitor: one expectation per edge, sampled just after it.
  always begin
    fields_t act;
    exp_t e;
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      act.ctrl  = {exe_cmd, mem_read, mem_write, wb_en, branch_en, status_s};
      act.pc    = pc;
      act.rn    = rn_val;
      act.rm    = rm_val;
      act.imm   = imm;
      act.sh    = shift_operand;
      act.simm  = simm24;
      act.dest  = dest;
      act.s1    = src1_out;
      act.s2    = src2_out;
      act.one   = one_input_out;
      act.carry = carry;
      checks = checks + 3;
      if (act !== e.f) begin
        errors = errors + 1;
        $display("FAIL fields cyc=%0d got=%h want=%h", cyc, act, e.f);
      end
      if (valid !== e.valid) begin
        errors = errors + 1;
        $display("FAIL valid cyc=%0d got=%b want=%b", cyc, valid, e.valid);
      end
      if (bubble_count !== e.bc) begin
        errors = errors + 1;
        $display("FAIL bubble_count cyc=%0d got=%0d want=%0d", cyc, bubble_count, e.bc);
      end
    end
  end

  initial begin
    fields_t z, a, b, c, d, e, f;
    z = '0;
    a = '{ctrl: 9'b0010_0_0_1_0_1, pc: 32'h10, rn: 32'd5, rm: 32'd7, imm: 1'b1,
          sh: 12'h123, simm: 24'h0ABCDE, dest: 4'd2, s1: 4'd3, s2: 4'd4, one: 1'b0, carry: 1'b1};
    b = '{ctrl: 9'b0100_0_0_1_0_0, pc: 32'h14, rn: 32'hDEAD_BEEF, rm: 32'h1234_5678, imm: 1'b0,
          sh: 12'hFFF, simm: 24'hFFFFFF, dest: 4'd9, s1: 4'd10, s2: 4'd11, one: 1'b1, carry: 1'b0};
    c = '{ctrl: 9'b0010_0_1_0_0_0, pc: 32'h18, rn: 32'h100, rm: 32'h55, imm: 1'b1,
          sh: 12'h004, simm: 24'h000001, dest: 4'd1, s1: 4'd6, s2: 4'd1, one: 1'b0, carry: 1'b1};
    d = '{ctrl: 9'b1111_1_1_1_1_1, pc: 32'hFFFF_FFFF, rn: 32'hFFFF_FFFF, rm: 32'hFFFF_FFFF, imm: 1'b1,
          sh: 12'hFFF, simm: 24'hFFFFFF, dest: 4'hF, s1: 4'hF, s2: 4'hF, one: 1'b1, carry: 1'b1};
    e = '{ctrl: 9'b0000_0_0_0_1_0, pc: 32'h40, rn: 32'h0, rm: 32'h0, imm: 1'b0,
          sh: 12'h000, simm: 24'h800000, dest: 4'd0, s1: 4'd15, s2: 4'd0, one: 1'b1, carry: 1'b0};
    f = '{ctrl: 9'b0101_1_0_1_0_1, pc: 32'h80, rn: 32'h7, rm: 32'h8, imm: 1'b0,
          sh: 12'hABC, simm: 24'h123456, dest: 4'd12, s1: 4'd3, s2: 4'd5, one: 1'b0, carry: 1'b1};

    // Reset with random inputs, also with flush/freeze high.
    step(1'b0, 1'b0, 1'b0, rnd_fields(), z, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b1, rnd_fields(), z, 1'b0, 4'd0);
    // Normal load, then freeze with changed inputs for 3 cycles.
    step(1'b1, 1'b0, 1'b0, a, a, 1'b1, 4'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, b, a, 1'b1, 4'd0);
    step(1'b1, 1'b0, 1'b0, b, b, 1'b1, 4'd0);
    // STR loaded, then flush over freeze with all-ones inputs.
    step(1'b1, 1'b0, 1'b0, c, c, 1'b1, 4'd0);
    step(1'b1, 1'b1, 1'b1, d, z, 1'b0, 4'd1);
    step(1'b1, 1'b1, 1'b0, d, z, 1'b0, 4'd1);
    step(1'b1, 1'b0, 1'b1, d, z, 1'b0, 4'd2);
    step(1'b1, 1'b0, 1'b0, e, e, 1'b1, 4'd2);
    step(1'b1, 1'b1, 1'b0, d, e, 1'b1, 4'd2);
    // Reset beats flush.
    step(1'b0, 1'b0, 1'b1, d, z, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, a, a, 1'b1, 4'd0);
    // Continuous flush: count climbs to 15 and sticks.
    for (int i = 1; i <= 20; i++)
      step(1'b1, 1'b0, 1'b1, rnd_fields(), z, 1'b0, (i >= 15) ? 4'd15 : 4'(i));
    step(1'b1, 1'b1, 1'b1, d, z, 1'b0, 4'd15);
    step(1'b1, 1'b0, 1'b0, f, f, 1'b1, 4'd15);
    step(1'b1, 1'b1, 1'b0, a, f, 1'b1, 4'd15);
    step(1'b0, 1'b1, 1'b0, a, z, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, c, c, 1'b1, 4'd0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_reg.md
Name: id_stage_reg

Overview:
- ID/EX pipeline register sitting directly downstream of the decode-stage control unit in the 5-stage ARM-subset lab core.
- Captures the control unit's 9-bit control bundle plus the ID-stage operands every clock, and presents them to the EXE stage.
- Supports hazard freeze (hold contents) and branch flush (inject a bubble).
- Keeps a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 32, width of PC and register operand values
- CNT_W, 16, width of the bubble counter

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- freeze  input  1  hazard stall from hazard unit; hold all registers
- flush  input  1  branch taken in EXE; load bubble
- ctrl_in  input  9  {exe_cmd[3:0], mem_read, mem_write, wb_en, branch_en, status_s} from control unit
- one_input_in  input  1  instruction reads Rn only (no Rm dependency) flag from control unit
- pc_in  input  DATA_W  PC+4 of the instruction in ID
- rn_val_in, rm_val_in  input  DATA_W  register file read data
- imm_in  input  1  immediate operand flag
- shift_operand_in  input  12  shifter operand field
- simm24_in  input  24  branch offset
- dest_in, src1_in, src2_in  input  4  register indices
- carry_in  input  1  C flag from status register
- exe_cmd, mem_read, mem_write, wb_en, branch_en, status_s  output  4/1/1/1/1/1  registered control
- pc, rn_val, rm_val  output  DATA_W  registered data
- imm, shift_operand, simm24, dest, carry  output  1/12/24/4/1  registered fields
- src1_out, src2_out, one_input_out  output  4/4/1  forwarding info (see Optional Feature)
- valid  output  1  stage holds a real instruction (not a bubble)
- bubble_count  output  CNT_W  number of flush bubbles injected

Behaviour:
- Reset (rst_n=0 at clk edge): every output 0, including valid and bubble_count. Reset has priority over flush and freeze.
- Priority order: rst_n low > flush > freeze > normal load.
- Normal load (no flush, no freeze): all outputs take their *_in values on the next edge; valid <= 1. Latency is exactly 1 cycle.
- Flush: on the next edge, exe_cmd=0, mem_read=0, mem_write=0, wb_en=0, branch_en=0, status_s=0, valid=0, and all data, index and flag outputs are 0.
  - bubble_count increments by 1 and saturates at all-ones (no wrap).
- Flush with freeze both high: flush wins. The bubble is loaded and counted.
- Freeze only: all outputs, valid and bubble_count hold their values.
- A bubble must never assert any side-effecting control bit: wb_en, mem_write, mem_read, branch_en or status_s.
- status_s is passed through unmodified. The control unit already forces it to 0 for branches.
- Flush asserted for N consecutive cycles: N bubbles are counted, and the outputs stay zero.

Optional Feature:
- Macro: ID_STAGE_FWD_EN.
- Defined: src1_out, src2_out and one_input_out are registered with the same reset, flush (to 0), freeze and load rules as the other fields. This feeds the EXE forwarding unit.
- Undefined: these three outputs are tied to constant 0 and no flops are built for them. The forwarding unit is then disabled and hazards are resolved by freeze only.

Decomposition:
- Shared package core_pkg holds:
  - control bundle bit positions (EXE_CMD_MSB=8, MEM_R=4, MEM_W=3, WB=2, BR=1, S=0)
  - exe_cmd encodings (MOV=0001, ADD=0010, ADC=0011, SUB=0100, SBC=0101, AND=0110, ORR=0111, EOR=1000, MVN=1001)
  - mode encodings (COMPUTE=00, MEMORY=01, BRANCH=10)
- One sub-module, pipe_field_reg: a parameterised-width register with rst_n, flush (load 0), freeze (hold) and d/q. It is instantiated per field group. The counter logic stays in the top level.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with random inputs -> every output 0, valid=0, bubble_count=0.
- Normal load: ctrl_in=9'b0010_0_0_1_0_1 (ADD, wb, S), pc_in=0x10, rn_val_in=5 -> next edge exe_cmd=0010, wb_en=1, status_s=1, pc=0x10, rn_val=5, valid=1.
- Freeze: after the load above, freeze=1 for 3 cycles with changed inputs -> outputs unchanged for all 3; first edge after freeze drops they update.
- Flush over freeze: STR loaded (mem_write=1), then flush=1 and freeze=1 together -> mem_write=0, valid=0, all fields 0, bubble_count=1.
- Saturation: CNT_W=4, hold flush for 20 cycles -> bubble_count reaches 15 and stays 15.
- Macro check: with ID_STAGE_FWD_EN, src1_in=3 loads to src1_out=3 and a flush clears it to 0; without the macro, src1_out=0 always.
